// File: rtl/ring_pkg.sv
// Shared types for ring counter consumers: monitor states, sample classes and
// the relation of a one-hot sample to the previous phase.
package ring_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ZERO    = 2'd0,
    ONEHOT  = 2'd1,
    ILLEGAL = 2'd2
  } sample_class_e;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    JUMP = 2'd2
  } relation_e;

endpackage

// File: rtl/ring_phase_decoder_if.sv
// Sample/status bundle between a ring counter consumer and its environment.
interface ring_phase_decoder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REV_W = 8
);
  localparam int unsigned PW = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] ring_in;
  logic             clr_err;
  logic [PW-1:0]    phase;
  logic             phase_valid;
  logic             locked;
  logic [REV_W-1:0] rev_cnt;
  logic             rev_pulse;
  logic             err_illegal;
  logic             err_skip;
  logic             err_sticky;

  modport master (
    output en, ring_in, clr_err,
    input  phase, phase_valid, locked, rev_cnt, rev_pulse,
           err_illegal, err_skip, err_sticky
  );

  modport slave (
    input  en, ring_in, clr_err,
    output phase, phase_valid, locked, rev_cnt, rev_pulse,
           err_illegal, err_skip, err_sticky
  );
endinterface

// File: rtl/ring_onehot_decode.sv
// Combinational classifier: ring vector -> {ZERO, ONEHOT, ILLEGAL} and the set
// bit index (meaningful only for ONEHOT).
module ring_onehot_decode
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned PW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring,
  output sample_class_e    cls,
  output logic [PW-1:0]    idx
);

  logic seen;
  logic multi;

  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (ring[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = PW'(i);
      end
    end
  end

  always_comb begin
    cls = ZERO;
    if (multi)     cls = ILLEGAL;
    else if (seen) cls = ONEHOT;
  end

endmodule

// File: rtl/ring_phase_decoder.sv
// Receive-side ring counter monitor: decodes phase, locks on forward rotation,
// counts revolutions and flags illegal or skipped samples.
module ring_phase_decoder
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned REV_W      = 8,
  parameter int unsigned LOCK_STEPS = 2
) (
  input logic              clk,
  input logic              rst,
  ring_phase_decoder_if.slave bus
);

  localparam int unsigned PW  = $clog2(WIDTH);
  localparam int unsigned LCW = $clog2(LOCK_STEPS + 1);

  state_e           state;
  logic [PW-1:0]    phase_q;
  logic             valid_q;
  logic             locked_q;
  logic [LCW-1:0]   lock_cnt;
  logic [REV_W-1:0] rev_q;
  logic             rev_pulse_q;
  logic             illegal_q;
  logic             skip_q;
  logic             sticky_q;

  sample_class_e    cls_c;
  logic [PW-1:0]    idx_c;
  logic [PW-1:0]    next_idx_c;
  relation_e        rel_c;

  ring_onehot_decode #(.WIDTH(WIDTH)) u_decode (
    .ring (bus.ring_in),
    .cls  (cls_c),
    .idx  (idx_c)
  );

  // Relation of the decoded index to the current reference phase
  always_comb begin
    next_idx_c = (phase_q == PW'(WIDTH - 1)) ? '0 : phase_q + PW'(1);
    rel_c      = JUMP;
    if (idx_c == phase_q)         rel_c = HOLD;
    else if (idx_c == next_idx_c) rel_c = STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      lock_cnt    <= '0;
      rev_q       <= '0;
      rev_pulse_q <= 1'b0;
      illegal_q   <= 1'b0;
      skip_q      <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      rev_pulse_q <= 1'b0;
      illegal_q   <= 1'b0;
      skip_q      <= 1'b0;

      if (state == FAULT) begin
        // Samples are ignored until software acknowledges the fault
        if (bus.clr_err) begin
          state    <= UNLOCKED;
          sticky_q <= 1'b0;
          lock_cnt <= '0;
          valid_q  <= 1'b0;
        end
      end else begin
        // A later error assignment in this cycle overrides the clear
        if (bus.clr_err) sticky_q <= 1'b0;

        if (bus.en) begin
          case (cls_c)
            ZERO: begin
              state    <= UNLOCKED;
              locked_q <= 1'b0;
              lock_cnt <= '0;
              valid_q  <= 1'b0;
            end
            ILLEGAL: begin
              illegal_q <= 1'b1;
              sticky_q  <= 1'b1;
              if (state == LOCKED) begin
                state    <= FAULT;
                locked_q <= 1'b0;
              end else begin
                lock_cnt <= '0;
                valid_q  <= 1'b0;
              end
            end
            ONEHOT: begin
              if (state == LOCKED) begin
                case (rel_c)
                  STEP: begin
                    phase_q <= idx_c;
                    if (phase_q == PW'(WIDTH - 1)) begin
                      rev_q       <= rev_q + REV_W'(1);
                      rev_pulse_q <= 1'b1;
                    end
                  end
                  JUMP: begin
                    skip_q   <= 1'b1;
                    sticky_q <= 1'b1;
                    state    <= FAULT;
                    locked_q <= 1'b0;
                  end
                  default: ;
                endcase
              end else if (!valid_q) begin
                phase_q  <= idx_c;
                valid_q  <= 1'b1;
                lock_cnt <= '0;
              end else begin
                case (rel_c)
                  STEP: begin
                    phase_q  <= idx_c;
                    lock_cnt <= lock_cnt + LCW'(1);
                    if (lock_cnt == LCW'(LOCK_STEPS - 1)) begin
                      state    <= LOCKED;
                      locked_q <= 1'b1;
                    end
                  end
                  JUMP: begin
                    phase_q  <= idx_c;
                    lock_cnt <= '0;
                  end
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = valid_q;
  assign bus.locked      = locked_q;
  assign bus.rev_cnt     = rev_q;
  assign bus.rev_pulse   = rev_pulse_q;
  assign bus.err_illegal = illegal_q;
  assign bus.err_skip    = skip_q;
  assign bus.err_sticky  = sticky_q;

endmodule
